// File: rtl/npn4_pkg.sv
// Shared types and constants for the 4-input truth-table sweep block.
package npn4_pkg;

    typedef logic [15:0] tt4_t;
    typedef logic [3:0]  minterm_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    localparam int       NUM_MINTERMS = 16;
    localparam int       MAX_LATENCY  = 4;
    localparam minterm_t LAST_MINTERM = minterm_t'(NUM_MINTERMS - 1);

endpackage

// File: rtl/npn4_sample_pipe.sv
// LATENCY-stage {valid, idx} delay line: tells the top which minterm y0 currently reflects.
module npn4_sample_pipe
    import npn4_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_valid,
    input  minterm_t push_idx,
    output logic     tail_valid,
    output minterm_t tail_idx
);

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : stage
            logic     valid_reg;
            minterm_t idx_reg;
            logic     valid_next;
            minterm_t idx_next;

            if (gi == 0) begin : g_head
                assign valid_next = push_valid;
                assign idx_next   = push_idx;
            end else begin : g_body
                assign valid_next = stage[gi-1].valid_reg;
                assign idx_next   = stage[gi-1].idx_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    idx_reg   <= '0;
                end else begin
                    valid_reg <= valid_next;
                    idx_reg   <= idx_next;
                end
            end
        end
    endgenerate

    assign tail_valid = stage[LATENCY-1].valid_reg;
    assign tail_idx   = stage[LATENCY-1].idx_reg;

endmodule

// File: rtl/npn4_tt_sweep.sv
// Exhaustive minterm sweep and truth-table capture for a 4-input function.
// Optional NPN4_TT_COMPARE_EN adds exp_tt_i / pass_o for on-chip comparison.
module npn4_tt_sweep
    import npn4_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic [3:0]  x_o,
    input  logic        y0_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] tt_o,
    output logic        tt_valid_o
`ifdef NPN4_TT_COMPARE_EN
    ,
    input  logic [15:0] exp_tt_i,
    output logic        pass_o
`endif
);

    sweep_state_e state_reg;
    minterm_t     x_reg;
    tt4_t         tt_reg;
    logic         tt_valid_reg;
    logic         done_reg;
    logic         busy_reg;
    logic         last_seen_reg;

    logic         start_accept;
    logic         push_valid;
    minterm_t     push_idx;
    logic         tail_valid;
    minterm_t     tail_idx;

    assign start_accept = start_i && ((state_reg == IDLE) || (state_reg == DONE));

    // A sample token is launched on every edge that loads a new minterm into x.
    assign push_valid = start_accept || ((state_reg == SWEEP) && (x_reg != LAST_MINTERM));
    assign push_idx   = start_accept ? minterm_t'(0) : x_reg + minterm_t'(1);

    npn4_sample_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_idx   (push_idx),
        .tail_valid (tail_valid),
        .tail_idx   (tail_idx)
    );

`ifdef NPN4_TT_COMPARE_EN
    logic pass_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_reg <= 1'b0;
        end else if (start_accept) begin
            pass_reg <= 1'b0;
        end else if ((state_reg == DRAIN) && last_seen_reg) begin
            pass_reg <= (tt_reg == exp_tt_i);
        end
    end

    assign pass_o = pass_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            tt_reg        <= '0;
            tt_valid_reg  <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            last_seen_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (tail_valid) begin
                tt_reg[tail_idx] <= y0_i;
                if (tail_idx == LAST_MINTERM) begin
                    last_seen_reg <= 1'b1;
                end
            end
            case (state_reg)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_reg     <= SWEEP;
                        busy_reg      <= 1'b1;
                        x_reg         <= '0;
                        tt_reg        <= '0;
                        tt_valid_reg  <= 1'b0;
                        last_seen_reg <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (x_reg == LAST_MINTERM) begin
                        state_reg <= DRAIN;
                    end else begin
                        x_reg <= x_reg + minterm_t'(1);
                    end
                end
                DRAIN: begin
                    // Completion is declared one edge after the last sample lands.
                    if (last_seen_reg) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        tt_valid_reg  <= 1'b1;
                        last_seen_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign x_o        = x_reg;
    assign tt_o       = tt_reg;
    assign tt_valid_o = tt_valid_reg;
    assign done_o     = done_reg;
    assign busy_o     = busy_reg;

endmodule
